multi_axis_step_controller: RTL and testbench

Parametrised N-axis stepper controller for PmodSTEP-style unipolar drivers, replacing the fixed two-axis top with duplicated drivers. One shared step-rate divider feeds per-axis channels. Each channel debounces its enable, direction and limit inputs, supports full-step (wave) or half-step drive per axis, and tracks signed position. It also offers limit-switch homing. The block sits between the RF/switch inputs and the PmodSTEP coil pins, with status exported to board LEDs.

---
 rtl/step_pkg.sv | 25 ++
 rtl/step_debounce.sv | 41 ++++
 rtl/multi_axis_step_controller.sv | 168 ++++++++++++++++
 tb/tb_multi_axis_step_controller.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/step_pkg.sv
// Shared types and constants for the multi-axis stepper controller:
// axis states, phase/state widths and the unipolar half-step phase table.
package step_pkg;

    localparam int STATE_W = 2;
    localparam int PHASE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        HOME    = 2'd2,
        BLOCKED = 2'd3
    } axis_state_e;

    // Entry p holds coils {A,B,C,D}; index 0 is the least significant nibble.
    localparam logic [7:0][3:0] PHASE_TABLE = {
        4'b1001, 4'b0001, 4'b0011, 4'b0010,
        4'b0110, 4'b0100, 4'b1100, 4'b1000
    };

    function automatic logic [3:0] phase_coil(input logic [PHASE_W-1:0] p);
        return PHASE_TABLE[p];
    endfunction

endpackage

// File: rtl/step_debounce.sv
// Two-flop synchroniser followed by a stable-count debouncer; the output
// follows the input only after DB_CYCLES consecutive stable samples.
module step_debounce #(
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_raw,
    output logic o_db
);

    localparam int CW = $clog2(DB_CYCLES + 1);

    logic          r_s1;
    logic          r_s2;
    logic          r_db;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_s1  <= 1'b0;
            r_s2  <= 1'b0;
            r_db  <= 1'b0;
            r_cnt <= '0;
        end else begin
            r_s1 <= i_raw;
            r_s2 <= r_s1;
            if (r_s2 == r_db) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(DB_CYCLES - 1)) begin
                r_db  <= r_s2;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_db = r_db;

endmodule

// File: rtl/multi_axis_step_controller.sv
// N-axis unipolar stepper controller: shared step-rate divider feeding
// per-axis run/home/limit FSMs with full- or half-step drive and position.
module multi_axis_step_controller
    import step_pkg::*;
#(
    parameter int N_AXES    = 2,
    parameter int STEP_DIV  = 1_000_000,
    parameter int DB_CYCLES = 1_000_000,
    parameter int POS_WIDTH = 16
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [N_AXES-1:0]             i_en,
    input  logic [N_AXES-1:0]             i_dir,
    input  logic [N_AXES-1:0]             i_half_step,
    input  logic [N_AXES-1:0]             i_limit,
    input  logic [N_AXES-1:0]             i_home_req,
    output logic [4*N_AXES-1:0]           o_coil,
    output logic [POS_WIDTH*N_AXES-1:0]   o_position,
    output logic [3*N_AXES-1:0]           o_status
);

    localparam int DW = $clog2(STEP_DIV);

    logic [DW-1:0] r_div;
    logic          w_tick;

    assign w_tick = (r_div == DW'(STEP_DIV - 1));

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_div <= '0;
        end else if (w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + DW'(1);
        end
    end

    for (genvar a = 0; a < N_AXES; a++) begin : g_axis
        logic                 w_en;
        logic                 w_dir;
        logic                 w_half;
        logic                 w_lim;
        logic                 r_hs1;
        logic                 r_hs2;
        logic                 r_hprev;
        logic                 w_hedge;
        axis_state_e          r_state;
        axis_state_e          w_state;
        logic [PHASE_W-1:0]   r_p;
        logic [PHASE_W-1:0]   w_p;
        logic [POS_WIDTH-1:0] r_pos;
        logic [POS_WIDTH-1:0] w_pos;
        logic                 r_homed;
        logic                 w_homed;
        logic [3:0]           r_coil;
        logic                 w_step;
        logic                 w_fwd;
        logic                 w_zero;
        logic [1:0]           w_mag;

        step_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_en (
            .i_clk(i_clk), .i_rst(i_rst),
            .i_raw(i_en[a]), .o_db(w_en)
        );
        step_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_dir (
            .i_clk(i_clk), .i_rst(i_rst),
            .i_raw(i_dir[a]), .o_db(w_dir)
        );
        step_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_half (
            .i_clk(i_clk), .i_rst(i_rst),
            .i_raw(i_half_step[a]), .o_db(w_half)
        );
        step_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_lim (
            .i_clk(i_clk), .i_rst(i_rst),
            .i_raw(i_limit[a]), .o_db(w_lim)
        );

        always_ff @(posedge i_clk or negedge i_rst) begin
            if (!i_rst) begin
                r_hs1   <= 1'b0;
                r_hs2   <= 1'b0;
                r_hprev <= 1'b0;
            end else begin
                r_hs1   <= i_home_req[a];
                r_hs2   <= r_hs1;
                r_hprev <= r_hs2;
            end
        end

        assign w_hedge = r_hs2 & ~r_hprev;
        // An odd phase in full-step mode takes a single half step to realign.
        assign w_mag   = (w_half || r_p[0]) ? 2'd1 : 2'd2;

        always_comb begin
            w_state = r_state;
            w_homed = r_homed;
            w_step  = 1'b0;
            w_fwd   = w_dir;
            w_zero  = 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_en) w_state = w_hedge ? HOME : RUN;
                end
                RUN: begin
                    if (!w_en) begin
                        w_state = IDLE;
                    end else if (!w_dir && w_lim) begin
                        w_state = BLOCKED;
                    end else if (w_hedge) begin
                        w_state = HOME;
                    end else begin
                        w_step = w_tick;
                    end
                end
                BLOCKED: begin
                    if (!w_en) begin
                        w_state = IDLE;
                    end else if (w_dir || !w_lim) begin
                        w_state = RUN;
                    end
                end
                HOME: begin
                    w_fwd = 1'b0;
                    if (!w_en) begin
                        w_state = IDLE;
                    end else if (w_lim) begin
                        w_state = IDLE;
                        w_homed = 1'b1;
                        w_zero  = 1'b1;
                    end else begin
                        w_step = w_tick;
                    end
                end
            endcase
            w_p   = r_p;
            w_pos = r_pos;
            if (w_step) begin
                w_p   = w_fwd ? r_p + {1'b0, w_mag} : r_p - {1'b0, w_mag};
                w_pos = w_fwd ? r_pos + POS_WIDTH'(w_mag)
                              : r_pos - POS_WIDTH'(w_mag);
            end
            if (w_zero) w_pos = '0;
        end

        always_ff @(posedge i_clk or negedge i_rst) begin
            if (!i_rst) begin
                r_state <= IDLE;
                r_p     <= '0;
                r_pos   <= '0;
                r_homed <= 1'b0;
                r_coil  <= 4'b0000;
            end else begin
                r_state <= w_state;
                r_p     <= w_p;
                r_pos   <= w_pos;
                r_homed <= w_homed;
                r_coil  <= (w_state == IDLE) ? 4'b0000 : phase_coil(w_p);
            end
        end

        assign o_coil[4*a +: 4]                   = r_coil;
        assign o_position[POS_WIDTH*a +: POS_WIDTH] = r_pos;
        assign o_status[3*a +: 3]                 = {r_homed, r_state};
    end

endmodule

// File: tb/tb_multi_axis_step_controller.sv
// Scenario bench for multi_axis_step_controller: expected axis-0 output
// events are queued with stimulus and matched as the outputs change.
module tb_multi_axis_step_controller;

    localparam int NA = 2;
    localparam int SD = 4;
    localparam int DB = 3;
    localparam int PW = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [NA-1:0]  en = '0;
    logic [NA-1:0]  dir = '0;
    logic [NA-1:0]  half = '0;
    logic [NA-1:0]  lim = '0;
    logic [NA-1:0]  hreq = '0;
    logic [4*NA-1:0]  coil;
    logic [PW*NA-1:0] pos;
    logic [3*NA-1:0]  status;

    multi_axis_step_controller #(
        .N_AXES(NA), .STEP_DIV(SD), .DB_CYCLES(DB), .POS_WIDTH(PW)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_dir(dir),
        .i_half_step(half), .i_limit(lim), .i_home_req(hreq),
        .o_coil(coil), .o_position(pos), .o_status(status)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] st;
        logic [3:0] coil;
        logic [7:0] pos;
        logic [7:0] gap;
    } exp_t;

    exp_t        q[$];
    int          n_vec = 0;
    int          n_bad = 0;
    int          ev_cnt = 0;
    int          cyc = 0;
    int          last_cyc = 0;
    bit          mon_en = 1'b0;
    logic [14:0] last_snap = '0;
    logic [14:0] snap;

    assign snap = {status[2:0], coil[3:0], pos[7:0]};

    function automatic logic [3:0] ph(input int p);
        case (p & 7)
            0: return 4'b1000;
            1: return 4'b1100;
            2: return 4'b0100;
            3: return 4'b0110;
            4: return 4'b0010;
            5: return 4'b0011;
            6: return 4'b0001;
            default: return 4'b1001;
        endcase
    endfunction

    function automatic void push(input logic [2:0] st, input logic [3:0] c,
                                 input logic [7:0] p, input logic [7:0] g);
        exp_t e;
        e.st = st; e.coil = c; e.pos = p; e.gap = g;
        q.push_back(e);
    endfunction

    always @(posedge clk) begin
        #1;
        cyc++;
        if (mon_en && snap !== last_snap) begin
            exp_t e;
            ev_cnt++;
            n_vec++;
            if (q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_event: st=%b coil=%b pos=%0d, none expected",
                         snap[14:12], snap[11:8], $signed(snap[7:0]));
            end else begin
                e = q.pop_front();
                if (snap !== {e.st, e.coil, e.pos}) begin
                    n_bad++;
                    $display("FAIL event%0d: got st=%b coil=%b pos=%0d, want st=%b coil=%b pos=%0d",
                             ev_cnt, snap[14:12], snap[11:8], $signed(snap[7:0]),
                             e.st, e.coil, $signed(e.pos));
                end
                if (e.gap != 0) begin
                    n_vec++;
                    if (cyc - last_cyc != int'(e.gap)) begin
                        n_bad++;
                        $display("FAIL gap%0d: got %0d cycles, want %0d",
                                 ev_cnt, cyc - last_cyc, e.gap);
                    end
                end
            end
            last_cyc  = cyc;
            last_snap = snap;
        end
    end

    task automatic wait_ev(input int target, input int budget);
        for (int i = 0; i < budget && ev_cnt < target; i++) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if (coil !== '0) begin
            n_bad++; $display("FAIL reset_coil: got %h want 0", coil);
        end
        n_vec++;
        if (pos !== '0) begin
            n_bad++; $display("FAIL reset_pos: got %h want 0", pos);
        end
        n_vec++;
        if (status !== '0) begin
            n_bad++; $display("FAIL reset_status: got %b want 0", status);
        end
        rst = 1'b1;
        last_snap = snap;
        mon_en = 1'b1;
    endtask

    task automatic test_half_step;
        int base;
        base = ev_cnt;
        push(3'b001, ph(0), 8'd0, 8'd0);
        push(3'b001, ph(1), 8'd1, 8'd0);
        push(3'b001, ph(2), 8'd2, 8'd4);
        en[0] = 1'b1; dir[0] = 1'b1; half[0] = 1'b1;
        wait_ev(base + 3, 60);
        n_vec++;
        if (ev_cnt < base + 3) begin
            n_bad++; $display("FAIL half_timeout: got %0d events want %0d", ev_cnt - base, 3);
        end
        en[0] = 1'b0;
        push(3'b001, ph(3), 8'd3, 8'd4);
        push(3'b000, 4'b0000, 8'd3, 8'd2);
        wait_ev(base + 5, 40);
        repeat (8) @(negedge clk);
        n_vec++;
        if (q.size() != 0) begin
            n_bad++; $display("FAIL half_drain: got %0d pending want 0", q.size());
            q.delete();
        end
        n_vec++;
        if ({coil[7:4], pos[15:8], status[5:3]} !== '0) begin
            n_bad++;
            $display("FAIL axis1_idle: got coil=%b pos=%0d st=%b want all 0",
                     coil[7:4], pos[15:8], status[5:3]);
        end
    endtask

    task automatic test_full_realign;
        int base;
        base = ev_cnt;
        push(3'b001, ph(3), 8'd3, 8'd0);
        push(3'b001, ph(2), 8'd2, 8'd0);
        en[0] = 1'b1; dir[0] = 1'b0;
        wait_ev(base + 2, 60);
        dir[0] = 1'b1; half[0] = 1'b0;
        push(3'b001, ph(1), 8'd1, 8'd4);
        push(3'b001, ph(2), 8'd2, 8'd4);
        push(3'b001, ph(4), 8'd4, 8'd4);
        wait_ev(base + 5, 40);
        en[0] = 1'b0;
        push(3'b001, ph(6), 8'd6, 8'd4);
        push(3'b000, 4'b0000, 8'd6, 8'd2);
        wait_ev(base + 7, 40);
        repeat (6) @(negedge clk);
        n_vec++;
        if (q.size() != 0) begin
            n_bad++; $display("FAIL realign_drain: got %0d pending want 0", q.size());
            q.delete();
        end
    endtask

    task automatic test_limit_block;
        int base;
        base = ev_cnt;
        push(3'b001, ph(6), 8'd6, 8'd0);
        push(3'b001, ph(5), 8'd5, 8'd0);
        en[0] = 1'b1; dir[0] = 1'b0; half[0] = 1'b1;
        wait_ev(base + 2, 60);
        lim[0] = 1'b1;
        push(3'b001, ph(4), 8'd4, 8'd4);
        push(3'b011, ph(4), 8'd4, 8'd2);
        wait_ev(base + 4, 40);
        repeat (16) @(negedge clk);
        n_vec++;
        if ({status[2:0], coil[3:0], pos[7:0]} !== {3'b011, ph(4), 8'd4}) begin
            n_bad++;
            $display("FAIL blocked_hold: got st=%b coil=%b pos=%0d want st=011 coil=%b pos=4",
                     status[2:0], coil[3:0], pos[7:0], ph(4));
        end
        dir[0] = 1'b1;
        push(3'b001, ph(4), 8'd4, 8'd0);
        push(3'b001, ph(5), 8'd5, 8'd0);
        push(3'b001, ph(6), 8'd6, 8'd4);
        wait_ev(base + 7, 60);
        en[0] = 1'b0; lim[0] = 1'b0;
        push(3'b001, ph(7), 8'd7, 8'd4);
        push(3'b000, 4'b0000, 8'd7, 8'd2);
        wait_ev(base + 9, 40);
        repeat (6) @(negedge clk);
        n_vec++;
        if (q.size() != 0) begin
            n_bad++; $display("FAIL limit_drain: got %0d pending want 0", q.size());
            q.delete();
        end
    endtask

    task automatic test_homing;
        int base;
        base = ev_cnt;
        push(3'b001, ph(7), 8'd7, 8'd0);
        push(3'b001, ph(6), 8'd6, 8'd0);
        en[0] = 1'b1; dir[0] = 1'b0; half[0] = 1'b1;
        wait_ev(base + 2, 60);
        hreq[0] = 1'b1; dir[0] = 1'b1;
        push(3'b010, ph(6), 8'd6, 8'd3);
        push(3'b010, ph(5), 8'd5, 8'd1);
        push(3'b010, ph(4), 8'd4, 8'd4);
        push(3'b010, ph(3), 8'd3, 8'd4);
        wait_ev(base + 6, 60);
        lim[0] = 1'b1;
        push(3'b010, ph(2), 8'd2, 8'd4);
        push(3'b100, 4'b0000, 8'd0, 8'd2);
        @(negedge clk);
        en[0] = 1'b0; hreq[0] = 1'b0;
        wait_ev(base + 8, 40);
        repeat (8) @(negedge clk);
        n_vec++;
        if (q.size() != 0) begin
            n_bad++; $display("FAIL home_drain: got %0d pending want 0", q.size());
            q.delete();
        end
        lim[0] = 1'b0; dir[0] = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_glitch;
        en[0] = 1'b1;
        repeat (2) @(negedge clk);
        en[0] = 1'b0;
        repeat (20) @(negedge clk);
        n_vec++;
        if (coil[3:0] !== 4'b0000) begin
            n_bad++; $display("FAIL glitch_coil: got %b want 0000", coil[3:0]);
        end
        n_vec++;
        if (status[2:0] !== 3'b100) begin
            n_bad++; $display("FAIL glitch_status: got %b want 100", status[2:0]);
        end
    endtask

    task automatic test_wrap_reset;
        int base;
        base = ev_cnt;
        push(3'b101, ph(2), 8'd0, 8'd0);
        for (int k = 1; k <= 128; k++)
            push(3'b101, ph(2 + k), 8'(k), (k == 1) ? 8'd0 : 8'd4);
        en[0] = 1'b1; dir[0] = 1'b1; half[0] = 1'b1;
        wait_ev(base + 129, 800);
        n_vec++;
        if (ev_cnt < base + 129) begin
            n_bad++; $display("FAIL wrap_timeout: got %0d events want 129", ev_cnt - base);
            q.delete();
        end
        n_vec++;
        if (pos[7:0] !== 8'h80) begin
            n_bad++; $display("FAIL wrap_pos: got %0d want -128", $signed(pos[7:0]));
        end
        mon_en = 1'b0;
        #2 rst = 1'b0;
        #1;
        n_vec++;
        if (coil !== '0) begin
            n_bad++; $display("FAIL async_coil: got %h want 0", coil);
        end
        n_vec++;
        if (pos !== '0) begin
            n_bad++; $display("FAIL async_pos: got %h want 0", pos);
        end
        n_vec++;
        if (status !== '0) begin
            n_bad++; $display("FAIL async_status: got %b want 0", status);
        end
        en = '0; dir = '0; half = '0; lim = '0; hreq = '0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_half_step();
        test_full_realign();
        test_limit_block();
        test_homing();
        test_glitch();
        test_wrap_reset();
        n_vec++;
        if (q.size() != 0) begin
            n_bad++; $display("FAIL leftover: got %0d pending want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
